// File: rtl/spi_master_cfg.sv
// spi_master_cfg: valid/ready SPI master with selectable CPOL/CPHA, bit order and slave select
module spi_master_cfg #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int NUM_SS    = 1,
  parameter bit MSB_FIRST = 1'b1,
  localparam int SW = NUM_SS > 1 ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [SW-1:0]     ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(2 * DATA_W);
  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d, rsh_q, rsh_d, rx_q, rx_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d, sclk_q, sclk_d, mosi_q, mosi_d, rxv_q, rxv_d;
  logic accept, tick, xtick, last, sample, drive;
  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction
  function automatic logic [DATA_W-1:0] shift(input logic [DATA_W-1:0] v, input logic b);
    return MSB_FIRST ? {v[DATA_W-2:0], b} : {b, v[DATA_W-1:1]};
  endfunction
  assign accept = tx_valid && state_q == IDLE;
  assign tick   = state_q != IDLE && cnt_q == '0;
  assign xtick  = state_q == XFER && tick;
  assign last   = bit_q == BW'(2 * DATA_W - 1);
  // bit_q[0]==0 marks a leading edge; cpha picks which edge samples
  assign sample = xtick && bit_q[0] == cpha_q;
  assign drive  = xtick && (bit_q[0] ? !cpha_q && !last : cpha_q);
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || tick) ? CW'(CLK_DIV - 1) : cnt_q - CW'(1);
    bit_d   = xtick ? bit_q + BW'(1) : bit_q;
    sh_d    = drive ? shift(sh_q, 1'b0) : sh_q;
    rsh_d   = sample ? shift(rsh_q, miso) : rsh_q;
    mosi_d  = drive ? first_bit(sh_q) : mosi_q;
    sclk_d  = xtick ? !sclk_q : sclk_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    ss_n_d  = ss_n_q;
    rx_d    = rx_q;
    rxv_d   = 1'b0;
    if (accept) begin
      state_d = LEAD;
      cpol_d  = cpol;
      cpha_d  = cpha;
      sclk_d  = cpol;
      bit_d   = '0;
      sh_d    = cpha ? tx_data : shift(tx_data, 1'b0);
      mosi_d  = cpha ? mosi_q : first_bit(tx_data);
      for (int i = 0; i < NUM_SS; i++) ss_n_d[i] = ss_sel != SW'(i);
    end
    if (tick) state_d = state_q == LEAD ? XFER : state_q == XFER ? (last ? TRAIL : XFER) : IDLE;
    if (tick && state_q == TRAIL) begin
      rx_d   = rsh_q;
      rxv_d  = 1'b1;
      ss_n_d = '1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      rsh_q   <= '0;
      rx_q    <= '0;
      ss_n_q  <= '1;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      rxv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      rsh_q   <= rsh_d;
      rx_q    <= rx_d;
      ss_n_q  <= ss_n_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      rxv_q   <= rxv_d;
    end
  end
  assign tx_ready = state_q == IDLE;
  assign busy     = state_q != IDLE;
  assign rx_data  = rx_q;
  assign rx_valid = rxv_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign ss_n     = ss_n_q;
endmodule

// File: tb/tb_spi_master_cfg.sv
// tb_spi_master_cfg: directed tests on a 4-select MSB-first master and a fast LSB-first master
module tb_spi_master_cfg;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] a_tx_data = 8'h00, a_rx_data;
  logic a_tx_valid = 1'b0, a_cpol = 1'b0, a_cpha = 1'b0;
  logic a_tx_ready, a_rx_valid, a_busy, a_sclk, a_mosi, a_miso;
  logic [1:0] a_ss_sel = 2'd0;
  logic [3:0] a_ss_n;
  logic [7:0] b_tx_data = 8'h00, b_rx_data;
  logic b_tx_valid = 1'b0, b_cpol = 1'b0, b_cpha = 1'b0;
  logic b_tx_ready, b_rx_valid, b_busy, b_sclk, b_mosi, b_miso;
  logic [0:0] b_ss_sel = 1'b0;
  logic [0:0] b_ss_n;
  logic a_loop = 1'b1;
  logic [7:0] s_word = 8'h00, s_rx = 8'h00, b_bits = 8'h00;
  logic s_out;
  int s_fall = 0, s_base = 0, s_n, a_rise = 0;
  int pass = 0, total = 0, lat = 0, low = 0;

  spi_master_cfg #(.DATA_W(8), .CLK_DIV(2), .NUM_SS(4), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .ss_sel(a_ss_sel), .cpol(a_cpol), .cpha(a_cpha), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
    .busy(a_busy), .sclk(a_sclk), .mosi(a_mosi), .miso(a_miso), .ss_n(a_ss_n));
  spi_master_cfg #(.DATA_W(8), .CLK_DIV(1), .NUM_SS(1), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .ss_sel(b_ss_sel), .cpol(b_cpol), .cpha(b_cpha), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .busy(b_busy), .sclk(b_sclk), .mosi(b_mosi), .miso(b_miso), .ss_n(b_ss_n));

  // slave for instance A: shifts s_word out MSB first, one bit per falling sclk
  assign s_n    = s_fall - s_base;
  assign s_out  = (s_n >= 1 && s_n <= 8) ? s_word[3'(8 - s_n)] : 1'b0;
  assign a_miso = a_loop ? a_mosi : s_out;
  assign b_miso = b_mosi;
  always @(negedge a_sclk) s_fall++;
  always @(posedge a_sclk) begin
    a_rise++;
    if (!a_ss_n[0]) s_rx = {s_rx[6:0], a_mosi};
  end
  always @(negedge b_sclk) if (!b_ss_n[0]) b_bits = {b_mosi, b_bits[7:1]};

  task automatic start_a(input logic [7:0] d, input logic [1:0] sel, input logic pol, input logic pha);
    @(negedge clk);
    a_tx_data = d; a_ss_sel = sel; a_cpol = pol; a_cpha = pha; a_tx_valid = 1'b1;
    @(posedge clk); #1;
    a_tx_valid = 1'b0;
  endtask

  task automatic start_b(input logic [7:0] d);
    @(negedge clk);
    b_tx_data = d; b_cpol = 1'b0; b_cpha = 1'b1; b_tx_valid = 1'b1;
    @(posedge clk); #1;
    b_tx_valid = 1'b0;
  endtask

  task automatic wait_a;
    lat = 0; low = 0;
    while (!a_rx_valid && lat < 200) begin
      if (a_ss_n != 4'hF) low++;
      @(posedge clk); #1; lat++;
    end
    total++; if (!a_rx_valid) $display("FAIL a_rx_valid_timeout after %0d cycles", lat); else pass++;
  endtask

  task automatic wait_b;
    lat = 0;
    while (!b_rx_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    total++; if (!b_rx_valid) $display("FAIL b_rx_valid_timeout after %0d cycles", lat); else pass++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (a_sclk !== 1'b0) $display("FAIL reset_sclk got %b exp 0", a_sclk); else pass++;
    total++; if (a_mosi !== 1'b0) $display("FAIL reset_mosi got %b exp 0", a_mosi); else pass++;
    total++; if (a_ss_n !== 4'hF) $display("FAIL reset_ss_n got %h exp f", a_ss_n); else pass++;
    total++; if (a_rx_data !== 8'h00) $display("FAIL reset_rx_data got %h exp 00", a_rx_data); else pass++;
    total++; if (a_rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b exp 0", a_rx_valid); else pass++;
    total++; if (a_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", a_busy); else pass++;
    total++; if (b_ss_n !== 1'b1) $display("FAIL reset_b_ss_n got %b exp 1", b_ss_n); else pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (a_tx_ready !== 1'b1) $display("FAIL reset_tx_ready got %b exp 1", a_tx_ready); else pass++;
    total++; if (b_tx_ready !== 1'b1) $display("FAIL reset_b_tx_ready got %b exp 1", b_tx_ready); else pass++;
  endtask

  task automatic test_mode0_loopback;
    a_loop = 1'b1; a_rise = 0;
    start_a(8'hA5, 2'd0, 1'b0, 1'b0);
    total++; if (a_ss_n !== 4'b1110) $display("FAIL t1_ss_n got %b exp 1110", a_ss_n); else pass++;
    total++; if (a_busy !== 1'b1 || a_tx_ready !== 1'b0) $display("FAIL t1_busy_ready got %b%b exp 10", a_busy, a_tx_ready); else pass++;
    total++; if (a_mosi !== 1'b1) $display("FAIL t1_first_mosi got %b exp 1", a_mosi); else pass++;
    wait_a;
    total++; if (lat != 36) $display("FAIL t1_latency got %0d exp 36", lat); else pass++;
    total++; if (low != 36) $display("FAIL t1_ss_low_cycles got %0d exp 36", low); else pass++;
    total++; if (a_rx_data !== 8'hA5) $display("FAIL t1_rx_data got %h exp a5", a_rx_data); else pass++;
    total++; if (a_rise != 8) $display("FAIL t1_sclk_rises got %0d exp 8", a_rise); else pass++;
    total++; if (a_ss_n !== 4'hF || a_tx_ready !== 1'b1) $display("FAIL t1_end_state got ss_n=%h ready=%b exp f 1", a_ss_n, a_tx_ready); else pass++;
    @(posedge clk); #1;
    total++; if (a_rx_valid !== 1'b0) $display("FAIL t1_rx_valid_width got %b exp 0", a_rx_valid); else pass++;
    total++; if (a_rx_data !== 8'hA5) $display("FAIL t1_rx_data_hold got %h exp a5", a_rx_data); else pass++;
  endtask

  task automatic test_mode3_slave;
    a_loop = 1'b0; s_word = 8'h3C; s_base = s_fall;
    start_a(8'hC3, 2'd0, 1'b1, 1'b1);
    total++; if (a_sclk !== 1'b1) $display("FAIL t2_sclk_lead got %b exp 1", a_sclk); else pass++;
    wait_a;
    total++; if (a_rx_data !== 8'h3C) $display("FAIL t2_rx_data got %h exp 3c", a_rx_data); else pass++;
    total++; if (s_rx !== 8'hC3) $display("FAIL t2_slave_rx got %h exp c3", s_rx); else pass++;
    total++; if (lat != 36) $display("FAIL t2_latency got %0d exp 36", lat); else pass++;
    @(posedge clk); #1;
    total++; if (a_sclk !== 1'b1) $display("FAIL t2_sclk_idle got %b exp 1", a_sclk); else pass++;
    a_loop = 1'b1;
  endtask

  task automatic test_ss_sel;
    start_a(8'h55, 2'd2, 1'b0, 1'b0);
    total++; if (a_ss_n !== 4'b1011) $display("FAIL t3_ss_n got %b exp 1011", a_ss_n); else pass++;
    a_ss_sel = 2'd1; a_tx_data = 8'h00; a_cpol = 1'b1; a_cpha = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++; if (a_ss_n !== 4'b1011) $display("FAIL t3_ss_n_mid got %b exp 1011", a_ss_n); else pass++;
    wait_a;
    total++; if (a_rx_data !== 8'h55) $display("FAIL t3_rx_data got %h exp 55", a_rx_data); else pass++;
    total++; if (a_ss_n !== 4'hF) $display("FAIL t3_ss_n_end got %b exp 1111", a_ss_n); else pass++;
    @(posedge clk); #1;
    total++; if (a_sclk !== 1'b0) $display("FAIL t3_sclk_idle got %b exp 0", a_sclk); else pass++;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    a_tx_data = 8'h01; a_ss_sel = 2'd0; a_cpol = 1'b0; a_cpha = 1'b0; a_tx_valid = 1'b1;
    @(posedge clk); #1;
    a_tx_data = 8'h80;
    wait_a;
    total++; if (a_rx_data !== 8'h01) $display("FAIL t4_rx_first got %h exp 01", a_rx_data); else pass++;
    total++; if (a_ss_n !== 4'hF || a_tx_ready !== 1'b1) $display("FAIL t4_gap got ss_n=%h ready=%b exp f 1", a_ss_n, a_tx_ready); else pass++;
    @(posedge clk); #1;
    total++; if (a_ss_n !== 4'b1110 || a_busy !== 1'b1) $display("FAIL t4_second_accept got ss_n=%b busy=%b exp 1110 1", a_ss_n, a_busy); else pass++;
    a_tx_valid = 1'b0;
    wait_a;
    total++; if (a_rx_data !== 8'h80) $display("FAIL t4_rx_second got %h exp 80", a_rx_data); else pass++;
    total++; if (lat != 36) $display("FAIL t4_latency got %0d exp 36", lat); else pass++;
  endtask

  task automatic test_reset_abort;
    int seen;
    start_a(8'hFF, 2'd0, 1'b1, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    total++; if (a_busy !== 1'b1 || a_sclk !== 1'b1) $display("FAIL t5_pre_busy_sclk got %b%b exp 11", a_busy, a_sclk); else pass++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (a_ss_n !== 4'hF) $display("FAIL t5_ss_n got %b exp 1111", a_ss_n); else pass++;
    total++; if (a_sclk !== 1'b0) $display("FAIL t5_sclk got %b exp 0", a_sclk); else pass++;
    total++; if (a_busy !== 1'b0) $display("FAIL t5_busy got %b exp 0", a_busy); else pass++;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (a_rx_valid) seen++;
    end
    total++; if (seen != 0) $display("FAIL t5_rx_valid_pulses got %0d exp 0", seen); else pass++;
    total++; if (a_tx_ready !== 1'b1) $display("FAIL t5_tx_ready got %b exp 1", a_tx_ready); else pass++;
  endtask

  task automatic test_lsb_first;
    start_b(8'h5A);
    wait_b;
    total++; if (lat != 18) $display("FAIL t6_latency got %0d exp 18", lat); else pass++;
    total++; if (b_rx_data !== 8'h5A) $display("FAIL t6_rx_data got %h exp 5a", b_rx_data); else pass++;
    total++; if (b_bits !== 8'h5A) $display("FAIL t6_wire_bits got %h exp 5a", b_bits); else pass++;
    @(posedge clk); #1;
    start_b(8'h13);
    total++; if (b_busy !== 1'b1 || b_ss_n !== 1'b0) $display("FAIL t6_busy_ss got %b%b exp 10", b_busy, b_ss_n); else pass++;
    wait_b;
    total++; if (b_rx_data !== 8'h13) $display("FAIL t6_rx_data2 got %h exp 13", b_rx_data); else pass++;
    total++; if (b_bits !== 8'h13) $display("FAIL t6_wire_bits2 got %h exp 13", b_bits); else pass++;
  endtask

  initial begin
    test_reset;
    test_mode0_loopback;
    test_mode3_slave;
    test_ss_sel;
    test_back_to_back;
    test_reset_abort;
    test_lsb_first;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
